cordic_feeder: RTL

Stream front-end for the fixed-angle `cordic` rotator. It buffers incoming Q8.7 vector pairs in a small FIFO and sequences the rotator's `start`/`ready` handshake one vector at a time. It captures each rotated result into an output register with valid/ready flow control, and returns a caller tag with the result. It sits directly upstream and downstream of `cordic`, and is the only block that drives that rotator.

---
 rtl/cordic_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 56 +++++
 rtl/cordic_feeder.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// cordic_pkg: types and constants shared by the cordic_feeder slice.
//   cvec_t          - one signed Q8.7 vector pair (v0 in the upper half)
//   feed_state_t    - sequencer states of cordic_feeder
//   CORDIC_BUSY_CYC - cycles the attached rotator keeps ready low after start
package cordic_pkg;

  localparam int CORDIC_BUSY_CYC = 10;

  typedef struct packed {
    logic signed [15:0] v0;
    logic signed [15:0] v1;
  } cvec_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } feed_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, W bits wide, DEPTH entries (power of two).
// Ports:
//   clk, reset (async, active low) - only the pointers are reset
//   push/din   - write when push && !full
//   pop/dout   - dout shows the head; pop advances when !empty
//   full, empty, level - occupancy status derived from the pointers
// Simultaneous push and pop are both honoured. A pushed entry becomes
// visible at dout one cycle later (no fall-through).
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]  wr_ptr, rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         push_ok, pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign level = LW'(wr_ptr - rd_ptr);
  assign full  = (level == LW'(DEPTH));
  assign empty = (wr_ptr == rd_ptr);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is deliberately not reset; stale entries are never visible
  // because empty is derived from the reset pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/cordic_feeder.sv
// cordic_feeder: stream front-end for the fixed-angle cordic rotator.
// Buffers input vectors in a FIFO, runs one vector at a time through the
// rotator's start/ready handshake and holds each result in a valid/ready
// output register together with its caller tag.
// Ports:
//   clk, reset (async, active low)
//   in_valid/in_ready/in_v0/in_v1/in_tag     - input stream (Q8.7 pairs)
//   out_valid/out_ready/out_v0/out_v1/out_tag - result stream
//   cr_reset/cr_start/cr_ready/cr_v*_i/cr_v*_o - rotator control and data
//   level - FIFO occupancy, err - sticky watchdog error
// Optional feature: define CORDIC_FEED_TIMEOUT_EN to add a BUSY watchdog
// that drops a stuck vector, resets the rotator and sets err.
module cordic_feeder
  import cordic_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int TAG_W       = 4,
  parameter int TIMEOUT_CYC = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [15:0]                in_v0,
  input  logic [15:0]                in_v1,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [15:0]                out_v0,
  output logic [15:0]                out_v1,
  output logic [TAG_W-1:0]           out_tag,
  output logic                       cr_reset,
  output logic                       cr_start,
  input  logic                       cr_ready,
  output logic [15:0]                cr_v0_i,
  output logic [15:0]                cr_v1_i,
  input  logic [15:0]                cr_v0_o,
  input  logic [15:0]                cr_v1_o,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       err
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int FW = TAG_W + $bits(cvec_t);

  // Elaboration-time parameter sanity.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("cordic_feeder: DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("cordic_feeder: TIMEOUT_CYC must be >= 2");
  end

  feed_state_t      state;
  logic             alive;      // low in reset, keeps in_ready low there
  logic [1:0]       rst_sr;     // rotator reset stretcher
  logic             fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [FW-1:0]    fifo_din, fifo_dout;
  cvec_t            head_vec, op_q;
  logic [TAG_W-1:0] head_tag, op_tag_q;
  logic             capture, to_hit;

  // ---------------- input FIFO ----------------
  assign in_ready  = alive && !fifo_full;
  assign fifo_push = in_valid && in_ready;
  assign fifo_din  = {in_tag, in_v0, in_v1};
  assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
  assign {head_tag, head_vec} = fifo_dout;

  sync_fifo #(.W(FW), .DEPTH(DEPTH), .LW(LW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) alive <= 1'b0;
    else        alive <= 1'b1;
  end

  // Rotator reset: held high in reset and for two edges after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sr <= 2'b11;
    else        rst_sr <= {rst_sr[0], 1'b0};
  end

  // Operands stay put from ISSUE until the next pop.
  assign cr_v0_i = op_q.v0;
  assign cr_v1_i = op_q.v1;

  // Result capture needs a finished rotation and a free (or freeing) slot.
  assign capture = (state == ST_BUSY) && cr_ready && (!out_valid || out_ready);

  // ---------------- sequencer + output register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cr_start  <= 1'b0;
      op_q      <= '0;
      op_tag_q  <= '0;
      out_valid <= 1'b0;
      out_v0    <= '0;
      out_v1    <= '0;
      out_tag   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fifo_pop) begin
            op_q     <= head_vec;
            op_tag_q <= head_tag;
            cr_start <= 1'b1;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cr_start <= 1'b0;
          state    <= ST_BUSY;
        end
        ST_BUSY: begin
          if (capture)     state <= ST_IDLE;
          else if (to_hit) state <= ST_IDLE;  // vector dropped, no output
        end
        default: begin
          cr_start <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase

      // A capture in the same cycle as an accept overwrites the slot.
      if (capture) begin
        out_valid <= 1'b1;
        out_v0    <= cr_v0_o;
        out_v1    <= cr_v1_o;
        out_tag   <= op_tag_q;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // ---------------- optional BUSY watchdog ----------------
`ifdef CORDIC_FEED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] to_cnt;
  logic          err_q, to_rst_q;

  // Fires on the TIMEOUT_CYC-th consecutive BUSY cycle with ready low.
  assign to_hit = (state == ST_BUSY) && !cr_ready && (to_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt   <= '0;
      err_q    <= 1'b0;
      to_rst_q <= 1'b0;
    end else begin
      if (state == ST_BUSY && !cr_ready && !to_hit) to_cnt <= to_cnt + 1'b1;
      else                                          to_cnt <= '0;
      err_q    <= err_q | to_hit;
      to_rst_q <= to_hit;
    end
  end

  assign err      = err_q;
  assign cr_reset = rst_sr[1] | to_rst_q;
`else
  assign to_hit   = 1'b0;
  assign err      = 1'b0;
  assign cr_reset = rst_sr[1];
`endif

endmodule
